// File: rtl/compare_pkg.sv
// Shared types for the compare scheduler: FSM state encoding and comparator flag bundle.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic xgy;
    logic xey;
    logic xly;
  } cmp_flags_t;

endpackage

// File: rtl/compare_core.sv
// Purely combinational unsigned magnitude comparator shared by every requester.
module compare_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             XGY,
  output logic             XEY,
  output logic             XLY
);

  assign XGY = (X > Y);
  assign XEY = (X == Y);
  assign XLY = (X < Y);

endmodule

// File: rtl/compare_sched.sv
// Round-robin scheduler feeding one shared comparator; IDLE -> CMP -> RESP per request.
// Optional macro COMPARE_SCHED_STATS_EN adds a 16-bit wrapping handshake counter output cmp_count.
module compare_sched
  import compare_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_xgy,
  output logic                    rsp_xey,
  output logic                    rsp_xly,
  output logic                    busy
`ifdef COMPARE_SCHED_STATS_EN
  ,
  output logic [15:0]             cmp_count
`endif
);

  localparam int IDW = $clog2(NREQ);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic             found;
  logic [IDW-1:0]   cap_id;
  logic [WIDTH-1:0] cap_x;
  logic [WIDTH-1:0] cap_y;
  cmp_flags_t       core_flags;
  cmp_flags_t       rsp_flags;
  logic             rsp_hs;

  // First requesting index at or above rr_ptr, wrapping at NREQ.
  always_comb begin : pick
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst) req_ready[winner] = 1'b1;
  end

  compare_core #(.WIDTH(WIDTH)) u_core (
    .X   (cap_x),
    .Y   (cap_y),
    .XGY (core_flags.xgy),
    .XEY (core_flags.xey),
    .XLY (core_flags.xly)
  );

  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_id    <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cap_id <= winner;
            cap_x  <= req_x[int'(winner)*WIDTH +: WIDTH];
            cap_y  <= req_y[int'(winner)*WIDTH +: WIDTH];
            state  <= CMP;
          end
        end
        CMP: begin
          rsp_flags <= core_flags;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_xgy = rsp_flags.xgy;
  assign rsp_xey = rsp_flags.xey;
  assign rsp_xly = rsp_flags.xly;
  assign busy    = (state != IDLE);

`ifdef COMPARE_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmp_count <= 16'd0;
    else if (rsp_hs) cmp_count <= cmp_count + 16'd1;
  end
`endif

endmodule

// File: doc/compare_sched.md
COMPARE_SCHED -- requirements
Module: compare_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester request.
REQ-006 SHALL have port req_x  input  NREQ*WIDTH  packed X operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_y  input  NREQ*WIDTH  packed Y operands; same packing.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  $clog2(NREQ)  index of the served requester.
REQ-012 SHALL have ports rsp_xgy, rsp_xey, rsp_xly  output  1 each  unsigned X>Y, X==Y, X<Y.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CMP -> RESP -> IDLE.
REQ-015 In IDLE with any req_valid set, SHALL pick a winner round-robin: first set bit at or above rr_ptr, wrapping at NREQ.
REQ-016 In IDLE, SHALL drive req_ready[winner]=1 combinationally in that same cycle; all other req_ready bits and all bits outside IDLE SHALL be 0.
REQ-017 On the accept edge, SHALL capture the winner's X, Y and index, then enter CMP.
REQ-018 In CMP, SHALL register the three comparator flags and rsp_id, set rsp_valid=1 and enter RESP.
REQ-019 Latency: with request accepted in cycle N, rsp_valid SHALL rise in cycle N+2.
REQ-020 Exactly one of the xgy/xey/xly flags SHALL be 1 whenever rsp_valid=1.
REQ-021 In RESP, rsp_valid and all rsp_* outputs SHALL hold stable until rsp_valid&&rsp_ready.
REQ-022 On the rsp handshake: clear rsp_valid, set rr_ptr=(rsp_id+1) mod NREQ, and return to IDLE.
REQ-023 Maximum throughput SHALL be one result per 3 cycles when rsp_ready is held high.
REQ-024 A requester dropping req_valid before it is granted SHALL lose no state and SHALL NOT be served.
REQ-025 Operand changes after the accept edge SHALL NOT affect the result.

Reset
REQ-026 On rst: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, all flags=0, busy=0, req_ready=0.
REQ-027 Reset mid-operation SHALL discard the in-flight result without emitting it.
REQ-028 The first grant after reset SHALL go to the lowest valid index.

Configuration
REQ-029 Macro COMPARE_SCHED_STATS_EN, when defined, SHALL add output cmp_count (16 bits).
- cmp_count increments on each rsp handshake, wraps 0xFFFF->0, and resets to 0.
REQ-030 Without COMPARE_SCHED_STATS_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package compare_pkg SHALL hold the FSM state enum (IDLE, CMP, RESP) and the cmp_flags_t struct {xgy, xey, xly}.
REQ-032 SHALL instantiate one combinational sub-module compare_core (WIDTH parameter; inputs X, Y; outputs XGY, XEY, XLY), shared by all requesters.

Verification
REQ-033 Single request: req_valid=4'b0100, X=0x20, Y=0x10, rsp_ready=1 -> req_ready=4'b0100 in cycle N; rsp_valid in cycle N+2 with rsp_id=2, xgy=1.
REQ-034 Equality/extremes: X=Y=0xFF -> xey=1; X=0x00, Y=0xFF -> xly=1 (unsigned).
REQ-035 Fairness: req_valid=4'b1111 held high, rsp_ready=1 -> grant order 0,1,2,3,0; one result every 3 cycles.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, no req_ready pulse; release -> IDLE next cycle.
REQ-037 Reset in CMP -> no rsp_valid afterwards; next grant goes to index 0.
REQ-038 With STATS_EN: 0xFFFF handshakes followed by 1 more -> cmp_count=0.
